dram_cmd_scheduler: RTL and testbench
=====================================

DRAM_CMD_SCHEDULER -- requirements
Module: dram_cmd_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDRESS_WIDTH, 32, request address width; T_RCD, 4, ACT to RD/WR cycles; T_CL, 4, read latency; T_CWL, 3, write latency; T_BURST, 4, data burst cycles; T_WR, 4, write recovery; T_RAS, 10, ACT to PRE minimum; T_RP, 4, PRE to next ACT minimum; all timing parameters ≥1.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- req_valid  in  1  queue head holds a valid request (op_ready_s of the queue output entry)
- req_opcode  in  2  parsed_op_t: DATA_READ=0, DATA_WRITE=1, OPCODE_FETCH=2, NOP=3
- req_address  in  ADDRESS_WIDTH  request byte address
- req_pop  out  1  one-cycle pulse; head request consumed this cycle
- cmd  out  3  DRAM command: 0 NONE, 1 ACT, 2 RD, 3 WR, 4 PRE
- cmd_bg  out  2  bank group of cmd
- cmd_bank  out  2  bank of cmd
- cmd_row  out  10  row of cmd (ACT only, else 0)
- cmd_col  out  8  column of cmd (RD/WR only, else 0)
- busy  out  1  request in flight (state ≠ IDLE)
- done  out  1  one-cycle pulse; request fully retired

Function
REQ-003 Address decode SHALL be: bg = addr[7:6], bank = addr[9:8], col = addr[17:10], row = addr[27:18]; addr[5:0] and addr[31:28] ignored.
REQ-004 Policy SHALL be closed-page, in-order, one request in flight; every RD/WR is bracketed by its own ACT and PRE.
REQ-005 FSM states SHALL be IDLE, ACT, WAIT_RCD, RDWR, WAIT_PRE, PRE, WAIT_RP.
REQ-006 In IDLE with req_valid=1: req_pop=1 that cycle (t0), opcode/bg/bank/row/col latched; if opcode=NOP, stay IDLE, no command, no done.
REQ-007 For non-NOP: cmd=ACT with latched bg/bank/row at t0+1 (ta).
REQ-008 cmd=RD (DATA_READ or OPCODE_FETCH) or WR (DATA_WRITE) with latched bg/bank/col at ta+T_RCD (tc).
REQ-009 cmd=PRE with latched bg/bank at tp = max(ta+T_RAS, tc+T_CL+T_BURST) for reads, max(ta+T_RAS, tc+T_CWL+T_BURST+T_WR) for writes.
REQ-010 FSM SHALL re-enter IDLE at tp+T_RP with done=1 that cycle; req_pop may assert in that same cycle if req_valid=1.
REQ-011 Outside IDLE, req_pop SHALL be 0 regardless of req_valid; latched fields SHALL not change; input changes SHALL be ignored.
REQ-012 cmd SHALL be non-NONE for exactly one cycle per command; cmd_bg/cmd_bank/cmd_row/cmd_col SHALL be 0 whenever cmd=NONE.
REQ-013 All outputs except req_pop SHALL be registered; req_pop is combinational from state and req_valid.
REQ-014 Timing counters SHALL be wide enough for the largest derived interval without wrap; no interval may be shortened by saturation.
REQ-015 busy SHALL be 1 from t0+1 through tp+T_RP-1 inclusive, else 0.

Reset
REQ-016 reset=1 at a rising edge SHALL force state IDLE, cmd=NONE, all field outputs 0, busy=0, done=0, counters 0, on the next cycle; req_pop=0 while reset=1.
REQ-017 Reset mid-operation SHALL abandon the in-flight request with no PRE issued and no done; first request after reset follows REQ-006 normally.

Verification
REQ-018 Read: defaults, req_valid=1, DATA_READ, addr 0x0ABCDE40 at cycle 0 -> pop@0; ACT bg=1 bank=2 row=0x2AF @1; RD col=0x37 @5; PRE @13; done, IDLE @17.
REQ-019 Write: same address, DATA_WRITE -> ACT@1, WR@5, PRE@16, done@20; T_RAS=20 override -> PRE@21, done@25.
REQ-020 NOP: NOP head then DATA_READ head -> pop@0 with no command; pop@1, ACT@2.
REQ-021 Back-to-back: two reads held valid -> second pop coincides with first done @17, second ACT @18; no pops cycles 1-16.
REQ-022 Reset: assert reset at cycle 7 of a read -> cycle 8 cmd=NONE, busy=0, no PRE, no done; new read accepted after release.
REQ-023 Opcode fetch: OPCODE_FETCH -> RD (cmd=2) at identical timing to REQ-018.

Source files
------------

// File: rtl/dram_cmd_scheduler.sv
// Closed-page, in-order DRAM command scheduler: one request at a time, each
// RD/WR wrapped in its own ACT and PRE with JEDEC-style spacing.
module dram_cmd_scheduler #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int T_RCD         = 4,
   parameter int T_CL          = 4,
   parameter int T_CWL         = 3,
   parameter int T_BURST       = 4,
   parameter int T_WR          = 4,
   parameter int T_RAS         = 10,
   parameter int T_RP          = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     req_valid,
   input  logic [1:0]               req_opcode,
   input  logic [ADDRESS_WIDTH-1:0] req_address,
   output logic                     req_pop,
   output logic [2:0]               cmd,
   output logic [1:0]               cmd_bg,
   output logic [1:0]               cmd_bank,
   output logic [9:0]               cmd_row,
   output logic [7:0]               cmd_col,
   output logic                     busy,
   output logic                     done
);

   localparam int LAT_RD = T_CL + T_BURST;
   localparam int LAT_WR = T_CWL + T_BURST + T_WR;
   localparam int P_RD   = (T_RAS > T_RCD + LAT_RD) ? T_RAS : T_RCD + LAT_RD;
   localparam int P_WR   = (T_RAS > T_RCD + LAT_WR) ? T_RAS : T_RCD + LAT_WR;
   localparam int P_MAX  = (P_RD > P_WR) ? P_RD : P_WR;
   localparam int CW     = $clog2(P_MAX + T_RP + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ACT, S_WAIT_RCD, S_RDWR, S_WAIT_PRE, S_PRE, S_WAIT_RP
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2, CMD_WR = 3'd3, CMD_PRE = 3'd4
   } cmd_t;

   typedef enum logic [1:0] {
      OP_READ = 2'd0, OP_WRITE = 2'd1, OP_FETCH = 2'd2, OP_NOP = 2'd3
   } op_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   elapsed_q, elapsed_d, elapsed_nxt, pre_at, end_at;
   op_t             op_q, op_d;
   logic [1:0]      bg_q, bg_d, bank_q, bank_d;
   logic [9:0]      row_q, row_d;
   logic [7:0]      col_q, col_d;
   cmd_t            cmd_q, cmd_d;
   logic [1:0]      cmd_bg_q, cmd_bg_d, cmd_bank_q, cmd_bank_d;
   logic [9:0]      cmd_row_q, cmd_row_d;
   logic [7:0]      cmd_col_q, cmd_col_d;
   logic            busy_q, busy_d, done_q, done_d;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^{req_address[ADDRESS_WIDTH-1:28], req_address[5:0]};

   // elapsed counts cycles since the ACT cycle; every command slot is an offset from it
   always_comb begin
      state_d     = state_q;
      elapsed_d   = elapsed_q;
      op_d        = op_q;
      bg_d        = bg_q;
      bank_d      = bank_q;
      row_d       = row_q;
      col_d       = col_q;
      done_d      = 1'b0;
      req_pop     = (state_q == S_IDLE) && req_valid && !reset;
      pre_at      = (op_q == OP_WRITE) ? CW'(P_WR) : CW'(P_RD);
      end_at      = pre_at + CW'(T_RP);
      elapsed_nxt = elapsed_q + CW'(1);

      if (state_q == S_IDLE) begin
         if (req_valid) begin
            op_d      = op_t'(req_opcode);
            bg_d      = req_address[7:6];
            bank_d    = req_address[9:8];
            col_d     = req_address[17:10];
            row_d     = req_address[27:18];
            elapsed_d = '0;
            if (op_t'(req_opcode) != OP_NOP) state_d = S_ACT;
         end
      end else begin
         elapsed_d = elapsed_nxt;
         if (elapsed_nxt == CW'(T_RCD))     state_d = S_RDWR;
         else if (elapsed_nxt < CW'(T_RCD)) state_d = S_WAIT_RCD;
         else if (elapsed_nxt == pre_at)    state_d = S_PRE;
         else if (elapsed_nxt < pre_at)     state_d = S_WAIT_PRE;
         else if (elapsed_nxt == end_at) begin
            state_d   = S_IDLE;
            elapsed_d = '0;
            done_d    = 1'b1;
         end else                           state_d = S_WAIT_RP;
      end

      cmd_d      = CMD_NONE;
      cmd_bg_d   = '0;
      cmd_bank_d = '0;
      cmd_row_d  = '0;
      cmd_col_d  = '0;
      case (state_d)
         S_ACT: begin
            cmd_d      = CMD_ACT;
            cmd_bg_d   = bg_d;
            cmd_bank_d = bank_d;
            cmd_row_d  = row_d;
         end
         S_RDWR: begin
            cmd_d      = (op_d == OP_WRITE) ? CMD_WR : CMD_RD;
            cmd_bg_d   = bg_d;
            cmd_bank_d = bank_d;
            cmd_col_d  = col_d;
         end
         S_PRE: begin
            cmd_d      = CMD_PRE;
            cmd_bg_d   = bg_d;
            cmd_bank_d = bank_d;
         end
         default: ;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         elapsed_q  <= '0;
         op_q       <= OP_READ;
         bg_q       <= '0;
         bank_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         cmd_q      <= CMD_NONE;
         cmd_bg_q   <= '0;
         cmd_bank_q <= '0;
         cmd_row_q  <= '0;
         cmd_col_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         elapsed_q  <= elapsed_d;
         op_q       <= op_d;
         bg_q       <= bg_d;
         bank_q     <= bank_d;
         row_q      <= row_d;
         col_q      <= col_d;
         cmd_q      <= cmd_d;
         cmd_bg_q   <= cmd_bg_d;
         cmd_bank_q <= cmd_bank_d;
         cmd_row_q  <= cmd_row_d;
         cmd_col_q  <= cmd_col_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign cmd      = cmd_q;
   assign cmd_bg   = cmd_bg_q;
   assign cmd_bank = cmd_bank_q;
   assign cmd_row  = cmd_row_q;
   assign cmd_col  = cmd_col_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: per-cycle comparison against a schedule-time
// model, plus directed scenarios with hand-computed cycle offsets.
module tb_dram_cmd_scheduler;

   localparam int AW = 32, TRCD = 4, TCL = 4, TCWL = 3, TBURST = 4, TWR = 4, TRAS = 10, TRP = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic [1:0]    req_opcode = 2'd0;
   logic [AW-1:0] req_address = '0;

   logic       req_pop, busy, done;
   logic [2:0] cmd;
   logic [1:0] cmd_bg, cmd_bank;
   logic [9:0] cmd_row;
   logic [7:0] cmd_col;

   logic       req_pop2, busy2, done2;
   logic [2:0] cmd2;
   logic [1:0] cmd_bg2, cmd_bank2;
   logic [9:0] cmd_row2;
   logic [7:0] cmd_col2;

   dram_cmd_scheduler #(
      .ADDRESS_WIDTH(AW), .T_RCD(TRCD), .T_CL(TCL), .T_CWL(TCWL), .T_BURST(TBURST),
      .T_WR(TWR), .T_RAS(TRAS), .T_RP(TRP)
   ) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_opcode(req_opcode),
      .req_address(req_address), .req_pop(req_pop), .cmd(cmd), .cmd_bg(cmd_bg),
      .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .busy(busy), .done(done)
   );

   dram_cmd_scheduler #(
      .ADDRESS_WIDTH(AW), .T_RAS(20)
   ) dut_ras20 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_opcode(req_opcode),
      .req_address(req_address), .req_pop(req_pop2), .cmd(cmd2), .cmd_bg(cmd_bg2),
      .cmd_bank(cmd_bank2), .cmd_row(cmd_row2), .cmd_col(cmd_col2), .busy(busy2), .done(done2)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: one in-flight request described by its absolute event cycles.
   int         n = 0;
   bit         chk_en = 0;
   bit         m_have = 0;
   int         m_t0, m_ta, m_tc, m_tp, m_tend;
   logic [1:0] m_op, m_bg, m_bank;
   logic [9:0] m_row;
   logic [7:0] m_col;
   logic [2:0] e_cmd;
   logic [1:0] e_bg, e_bank;
   logic [9:0] e_row;
   logic [7:0] e_col;
   logic       e_busy, e_done, e_pop;

   int pop_cnt = 0, last_pop = -1, act_cyc = -1, rdwr_cyc = -1, pre_cyc = -1, done_cyc = -1;
   int pre_cnt = 0, done_cnt = 0, pre2_cyc = -1, done2_cyc = -1, done2_cnt = 0;
   logic [1:0] act_bg, act_bank;
   logic [9:0] act_row;
   logic [7:0] rd_col;
   logic [2:0] rdwr_cmd;

   always @(negedge clock) begin
      if (chk_en) begin
         e_cmd = 3'd0; e_bg = 2'd0; e_bank = 2'd0; e_row = 10'd0; e_col = 8'd0;
         if (m_have) begin
            if (n == m_ta) begin
               e_cmd = 3'd1; e_bg = m_bg; e_bank = m_bank; e_row = m_row;
            end else if (n == m_tc) begin
               e_cmd = (m_op == 2'd1) ? 3'd3 : 3'd2; e_bg = m_bg; e_bank = m_bank; e_col = m_col;
            end else if (n == m_tp) begin
               e_cmd = 3'd4; e_bg = m_bg; e_bank = m_bank;
            end
         end
         e_busy = m_have && n > m_t0 && n < m_tend;
         e_done = m_have && n == m_tend;
         e_pop  = (!m_have || n >= m_tend) && req_valid && !reset;
         chk("req_pop", 32'(req_pop), 32'(e_pop));
         chk("cmd", 32'(cmd), 32'(e_cmd));
         chk("cmd_bg", 32'(cmd_bg), 32'(e_bg));
         chk("cmd_bank", 32'(cmd_bank), 32'(e_bank));
         chk("cmd_row", 32'(cmd_row), 32'(e_row));
         chk("cmd_col", 32'(cmd_col), 32'(e_col));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("done", 32'(done), 32'(e_done));
         if (reset) m_have = 0;
         else if (e_pop && req_opcode != 2'd3) begin
            m_have = 1;
            m_op   = req_opcode;
            m_bg   = 2'((req_address >> 6) & 32'h3);
            m_bank = 2'((req_address >> 8) & 32'h3);
            m_col  = 8'((req_address >> 10) & 32'hFF);
            m_row  = 10'((req_address >> 18) & 32'h3FF);
            m_t0   = n;
            m_ta   = n + 1;
            m_tc   = m_ta + TRCD;
            m_tp   = (m_op == 2'd1) ? m_tc + TCWL + TBURST + TWR : m_tc + TCL + TBURST;
            if (m_ta + TRAS > m_tp) m_tp = m_ta + TRAS;
            m_tend = m_tp + TRP;
         end else if (m_have && n >= m_tend) m_have = 0;
      end
      if (req_pop === 1'b1) begin pop_cnt++; last_pop = n; end
      if (cmd === 3'd1) begin act_cyc = n; act_bg = cmd_bg; act_bank = cmd_bank; act_row = cmd_row; end
      if (cmd === 3'd2 || cmd === 3'd3) begin rdwr_cyc = n; rdwr_cmd = cmd; rd_col = cmd_col; end
      if (cmd === 3'd4) begin pre_cyc = n; pre_cnt++; end
      if (done === 1'b1) begin done_cyc = n; done_cnt++; end
      if (cmd2 === 3'd4) pre2_cyc = n;
      if (done2 === 1'b1) begin done2_cyc = n; done2_cnt++; end
      n++;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy !== 1'b0 && k < 100) begin step(); k++; end
      chk("idle_timeout", 32'(busy), 32'd0);
      step();
   endtask

   task automatic wait_done(input int base, input int budget, input string name);
      int k = 0;
      while (done_cnt == base && k < budget) begin step(); k++; end
      chk(name, 32'(done_cnt - base), 32'd1);
   endtask

   task automatic run_one(input logic [1:0] op, input logic [31:0] addr, output int c0);
      int base;
      wait_idle();
      base        = done_cnt;
      req_valid   = 1'b1;
      req_opcode  = op;
      req_address = addr;
      c0          = n;
      step();
      req_valid   = 1'b0;
      wait_done(base, 60, "done_timeout");
   endtask

   initial begin
      int c0, bp, bd, bpre, bd2;
      step();
      chk_en = 1;
      step();
      reset = 1'b0;

      // Read
      run_one(2'd0, 32'h0ABCDE40, c0);
      chk("rd_pop", 32'(last_pop - c0), 32'd0);
      chk("rd_act_t", 32'(act_cyc - c0), 32'd1);
      chk("rd_act_bg", 32'(act_bg), 32'd1);
      chk("rd_act_bank", 32'(act_bank), 32'd2);
      chk("rd_act_row", 32'(act_row), 32'h2AF);
      chk("rd_t", 32'(rdwr_cyc - c0), 32'd5);
      chk("rd_cmd", 32'(rdwr_cmd), 32'd2);
      chk("rd_col", 32'(rd_col), 32'h37);
      chk("rd_pre_t", 32'(pre_cyc - c0), 32'd13);
      chk("rd_done_t", 32'(done_cyc - c0), 32'd17);

      // Opcode fetch
      run_one(2'd2, 32'h0ABCDE40, c0);
      chk("of_act_t", 32'(act_cyc - c0), 32'd1);
      chk("of_rd_t", 32'(rdwr_cyc - c0), 32'd5);
      chk("of_cmd", 32'(rdwr_cmd), 32'd2);
      chk("of_pre_t", 32'(pre_cyc - c0), 32'd13);
      chk("of_done_t", 32'(done_cyc - c0), 32'd17);

      // Write, also on the T_RAS=20 instance
      do_reset();
      bd2 = done2_cnt;
      run_one(2'd1, 32'h0ABCDE40, c0);
      chk("wr_act_t", 32'(act_cyc - c0), 32'd1);
      chk("wr_t", 32'(rdwr_cyc - c0), 32'd5);
      chk("wr_cmd", 32'(rdwr_cmd), 32'd3);
      chk("wr_pre_t", 32'(pre_cyc - c0), 32'd16);
      chk("wr_done_t", 32'(done_cyc - c0), 32'd20);
      begin
         int k = 0;
         while (done2_cnt == bd2 && k < 40) begin step(); k++; end
      end
      chk("ras20_done_seen", 32'(done2_cnt - bd2), 32'd1);
      chk("ras20_pre_t", 32'(pre2_cyc - c0), 32'd21);
      chk("ras20_done_t", 32'(done2_cyc - c0), 32'd25);

      // NOP followed by a read
      wait_idle();
      bp = pop_cnt;
      bd = done_cnt;
      req_valid = 1'b1; req_opcode = 2'd3; req_address = 32'hFFFF_FFFF;
      c0 = n;
      step();
      req_opcode = 2'd0; req_address = 32'h0ABCDE40;
      step();
      req_valid = 1'b0;
      wait_done(bd, 60, "nop_done_timeout");
      chk("nop_pops", 32'(pop_cnt - bp), 32'd2);
      chk("nop_pop2_t", 32'(last_pop - c0), 32'd1);
      chk("nop_act_t", 32'(act_cyc - c0), 32'd2);

      // Back-to-back reads held valid
      wait_idle();
      bp = pop_cnt;
      bd = done_cnt;
      req_valid = 1'b1; req_opcode = 2'd0; req_address = 32'h0ABCDE40;
      c0 = n;
      begin
         int k = 0;
         while (pop_cnt - bp < 2 && k < 40) begin step(); k++; end
      end
      req_valid = 1'b0;
      chk("b2b_pops", 32'(pop_cnt - bp), 32'd2);
      chk("b2b_pop2_t", 32'(last_pop - c0), 32'd17);
      chk("b2b_done1_t", 32'(done_cyc - c0), 32'd17);
      wait_done(bd + 1, 60, "b2b_done_timeout");
      chk("b2b_act2_t", 32'(act_cyc - c0), 32'd18);
      chk("b2b_done2_t", 32'(done_cyc - c0), 32'd34);

      // Reset in the middle of a read
      wait_idle();
      req_valid = 1'b1; req_opcode = 2'd0; req_address = 32'h0ABCDE40;
      c0 = n;
      step();
      req_valid = 1'b0;
      repeat (6) step();
      bpre = pre_cnt;
      bd   = done_cnt;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_cycle", 32'(n - c0), 32'd8);
      chk("rst_cmd", 32'(cmd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (20) step();
      chk("rst_no_pre", 32'(pre_cnt - bpre), 32'd0);
      chk("rst_no_done", 32'(done_cnt - bd), 32'd0);
      run_one(2'd0, 32'h0ABCDE40, c0);
      chk("rst_next_act_t", 32'(act_cyc - c0), 32'd1);
      chk("rst_next_done_t", 32'(done_cyc - c0), 32'd17);

      // Randomized traffic with occasional resets
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         req_valid   = ($urandom_range(3) != 0);
         req_opcode  = 2'($urandom_range(3));
         req_address = $urandom;
         reset       = ($urandom_range(199) == 0);
         step();
      end
      reset = 1'b0;
      req_valid = 1'b0;
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
